dot_product_accumulator: RTL and testbench

//  Downstream consumer of the pipelined vedic multiplier in the matrix datapath.

---
 rtl/dot_product_accumulator.sv | 117 +++++++++++
 tb/tb_dot_product_accumulator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator behind a fixed-latency multiplier: issue tags ride a shift pipe
// alongside the product, and each finished sum is held on a valid/ready output register.
// Build option: define ACC_SAT_EN to make each add saturate at 2^ACC_W-1 instead of wrapping.
module dot_product_accumulator #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 12,
  parameter int MUL_LAT = 4,
  parameter int LEN     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_last,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              overrun,
  output logic              len_err
);

  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t             state_q;
  logic [MUL_LAT-1:0] tag_valid_q;
  logic [MUL_LAT-1:0] tag_last_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_data_q;
  logic               overrun_q;
  logic               len_err_q;

  logic               tag_v;
  logic               tag_l;
  logic [CNT_W-1:0]   cnt_d;
  logic               len_hit;
  logic               term_end;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   sum_d;

  assign tag_v    = tag_valid_q[MUL_LAT-1];
  assign tag_l    = tag_last_q[MUL_LAT-1];
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign len_hit  = (cnt_d == CNT_W'(LEN));
  assign term_end = tag_v & (tag_l | len_hit);
  assign prod_ext = ACC_W'(product);
  // A vector's first term starts from zero rather than from the stale accumulator.
  assign acc_base = (state_q == S_ACC) ? acc_q : '0;

`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum_full;
  assign sum_full = {1'b0, acc_base} + {1'b0, prod_ext};
  assign sum_d    = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign sum_d    = acc_base + prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      tag_valid_q[0] <= issue_valid;
      tag_last_q[0]  <= issue_valid & issue_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
      end

      if (tag_v) begin
        acc_q <= sum_d;
        if (term_end) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          if (!tag_l) len_err_q <= 1'b1;
        end else begin
          state_q <= S_ACC;
          cnt_q   <= cnt_d;
        end
      end

      // A held, unaccepted result wins; the newer sum is dropped and flagged.
      if (term_end) begin
        if (!out_valid_q || out_ready) begin
          out_valid_q <= 1'b1;
          out_data_q  <= sum_d;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;
  assign len_err   = len_err_q;
  assign busy      = (state_q == S_ACC) | (|tag_valid_q);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator; a 4-stage delay line stands in for the multiplier.
// Honours ACC_SAT_EN for the narrow-accumulator saturation check.
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_last;
  logic [7:0]  issue_prod;
  logic [7:0]  product;
  logic        out_ready;
  logic        out_valid, busy, overrun, len_err;
  logic [11:0] out_data;
  logic        out_valid9, busy9, overrun9, len_err9;
  logic [8:0]  out_data9;
  logic [7:0]  pipe [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Multiplier model: operands issued in cycle c give a product during cycle c+4.
  always @(posedge clk) begin
    pipe[0] <= issue_valid ? issue_prod : 8'hAA;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    pipe[3] <= pipe[2];
  end
  assign product = pipe[3];

  dot_product_accumulator #(.PROD_W(8), .ACC_W(12), .MUL_LAT(4), .LEN(4)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
    .product(product), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .overrun(overrun), .len_err(len_err)
  );

  dot_product_accumulator #(.PROD_W(8), .ACC_W(9), .MUL_LAT(4), .LEN(4)) dut9 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
    .product(product), .out_valid(out_valid9), .out_ready(out_ready),
    .out_data(out_data9), .busy(busy9), .overrun(overrun9), .len_err(len_err9)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] p, input logic last);
    issue_valid = 1'b1;
    issue_prod  = p;
    issue_last  = last;
    tick();
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    issue_prod  = 8'h00;
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_last = 1'b0; issue_prod = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_len_err", len_err, 0);
    rst = 1'b0;

    // 1: 3+5+7+9, last issued cycle 3, result visible cycle 8
    issue(8'd3, 1'b0); issue(8'd5, 1'b0); issue(8'd7, 1'b0); issue(8'd9, 1'b1);
    idle(0);
    chk("t1_busy_inflight", busy, 1);
    idle(3);
    chk("t1_not_early", out_valid, 0);
    idle(1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 24);
    chk("t1_busy_after", busy, 0);
    idle(2);
    chk("t1_held", out_valid, 1);
    chk("t1_held_data", out_data, 24);
    out_ready = 1'b1;
    idle(1);
    chk("t1_drained", out_valid, 0);

    // 2: back-to-back vectors, consumer always ready
    issue(8'd1, 1'b0); issue(8'd2, 1'b0); issue(8'd3, 1'b0); issue(8'd4, 1'b1);
    issue(8'd10, 1'b0); issue(8'd10, 1'b0); issue(8'd10, 1'b0); issue(8'd10, 1'b1);
    idle(0);
    chk("t2_first_valid", out_valid, 1);
    chk("t2_first_data", out_data, 10);
    idle(1);
    chk("t2_gap", out_valid, 0);
    idle(3);
    chk("t2_second_valid", out_valid, 1);
    chk("t2_second_data", out_data, 40);
    chk("t2_overrun", overrun, 0);
    idle(1);
    chk("t2_drained", out_valid, 0);

    // 3: same vectors with consumer stalled -> second result dropped
    out_ready = 1'b0;
    issue(8'd1, 1'b0); issue(8'd2, 1'b0); issue(8'd3, 1'b0); issue(8'd4, 1'b1);
    issue(8'd10, 1'b0); issue(8'd10, 1'b0); issue(8'd10, 1'b0); issue(8'd10, 1'b1);
    idle(0);
    chk("t3_first_data", out_data, 10);
    idle(4);
    chk("t3_kept_valid", out_valid, 1);
    chk("t3_kept_data", out_data, 10);
    chk("t3_overrun", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    chk("t3_one_transfer", out_valid, 0);
    idle(2);
    chk("t3_no_second", out_valid, 0);

    // 4: four terms without last hit LEN; fifth carries last
    pulse_reset();
    chk("t4_overrun_cleared", overrun, 0);
    issue(8'd2, 1'b0); issue(8'd2, 1'b0); issue(8'd2, 1'b0); issue(8'd2, 1'b0); issue(8'd2, 1'b1);
    idle(3);
    chk("t4_len_valid", out_valid, 1);
    chk("t4_len_data", out_data, 8);
    chk("t4_len_err", len_err, 1);
    idle(1);
    chk("t4_second_valid", out_valid, 1);
    chk("t4_second_data", out_data, 2);
    chk("t4_overrun", overrun, 0);
    idle(1);

    // 5: 4 x 255 in a 9-bit accumulator
    issue(8'd255, 1'b0); issue(8'd255, 1'b0); issue(8'd255, 1'b0); issue(8'd255, 1'b1);
    idle(4);
    chk("t5_wide_data", out_data, 1020);
    chk("t5_narrow_valid", out_valid9, 1);
`ifdef ACC_SAT_EN
    chk("t5_narrow_sat", out_data9, 511);
`else
    chk("t5_narrow_wrap", out_data9, 508);
`endif

    // 6: reset mid-vector discards partial sum and in-flight tags
    out_ready = 1'b0;
    issue(8'd50, 1'b0); issue(8'd60, 1'b0);
    pulse_reset();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_len_err", len_err, 0);
    idle(6);
    chk("t6_no_stray_result", out_valid, 0);
    chk("t6_no_stray_busy", busy, 0);
    out_ready = 1'b1;
    issue(8'd1, 1'b0); issue(8'd1, 1'b0); issue(8'd1, 1'b0); issue(8'd1, 1'b1);
    idle(4);
    chk("t6_next_valid", out_valid, 1);
    chk("t6_next_data", out_data, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
